// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 hex keypad column scanner with row sync, debounce and a
//            one-cycle valid strobe carrying the accepted key code.
// Revision : 1.0
// ============================================================================
module keypad_scanner #(
    parameter int SETTLE_CYCLES   = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] code,
    output logic       valid
);
    localparam int C_MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W        = $clog2(C_MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] C_ST_IDLE     = 3'd0;
    localparam logic [2:0] C_ST_SCAN     = 3'd1;
    localparam logic [2:0] C_ST_DEBOUNCE = 3'd2;
    localparam logic [2:0] C_ST_VALID    = 3'd3;
    localparam logic [2:0] C_ST_RELEASE  = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       code_q,    code_d;
    logic [3:0]       col_q,     col_d;
    logic [3:0]       row_meta_q, row_s_q;
    logic [1:0]       row_low;

    // Rows are asynchronous to clock; every decision looks at row_s_q only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_meta_q <= 4'b0000;
            row_s_q    <= 4'b0000;
        end else begin
            row_meta_q <= row;
            row_s_q    <= row_meta_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= C_ST_IDLE;
            cnt_q     <= '0;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            code_q    <= 4'h0;
            col_q     <= 4'b1111;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            code_q    <= code_d;
            col_q     <= col_d;
        end
    end

    always_comb begin
        row_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_s_q[i]) row_low = 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        code_d    = code_q;
        case (state_q)
            C_ST_IDLE: begin
                if (row_s_q != 4'b0000) begin
                    state_d   = C_ST_SCAN;
                    col_idx_d = 2'd0;
                    cnt_d     = '0;
                end
            end
            C_ST_SCAN: begin
                if (cnt_q == C_SETTLE_LAST) begin
                    cnt_d = '0;
                    if (row_s_q != 4'b0000) begin
                        row_idx_d = row_low;
                        state_d   = C_ST_DEBOUNCE;
                    end else if (col_idx_q == 2'd3) begin
                        state_d = C_ST_IDLE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            C_ST_DEBOUNCE: begin
                if (!row_s_q[row_idx_q]) begin
                    state_d = C_ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_DEB_LAST) begin
                    state_d = C_ST_VALID;
                    code_d  = {row_idx_q, col_idx_q};
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            C_ST_VALID: begin
                state_d = C_ST_RELEASE;
                cnt_d   = '0;
            end
            C_ST_RELEASE: begin
                // Only the captured key is watched; other keys wait for IDLE.
                if (row_s_q[row_idx_q]) begin
                    cnt_d = '0;
                end else if (cnt_q == C_DEB_LAST) begin
                    state_d = C_ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // col is registered from the next state so it always matches state_q.
    always_comb begin
        col_d = (state_d == C_ST_IDLE) ? 4'b1111 : (4'b0001 << col_idx_d);
        valid = (state_q == C_ST_VALID);
    end

    assign col  = col_q;
    assign code = code_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Self-checking bench for keypad_scanner driven through a 4x4
//            keypad row model; table vectors, corner sequences, random keys.
// Revision : 1.0
// ============================================================================
module tb_keypad_scanner;
    localparam int SETTLE  = 3;
    localparam int DEB     = 16;
    localparam int LAT_MAX = 2 + 1 + 4 * SETTLE + DEB + 1;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  code;
    logic        valid;
    logic [15:0] keys = 16'h0000;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  last_code = 4'h0;

    typedef struct {
        logic [15:0] keys;
        int          hold;
        int          exp_valids;
        logic [3:0]  exp_code;
    } vec_t;

    keypad_scanner #(
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .row     (row),
        .col     (col),
        .code    (code),
        .valid   (valid)
    );

    always #5 clock = ~clock;

    // Keypad: row[i] = OR_j (key[4i+j] & col[j])
    always_comb begin
        row = 4'b0000;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (keys[4*i+j] && col[j]) row[i] = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Winner: lowest column first, then lowest row inside that column.
    function automatic int winner(input logic [15:0] m);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (m[4*r+c]) return 4*r + c;
        return -1;
    endfunction

    task automatic run_phase(input logic [15:0] mask, input int hold, input int exp_n,
                             input logic [3:0] exp_code, input string tag);
        int         n_valid;
        int         n_rel;
        int         lat;
        bit         found;
        logic [3:0] col_at;
        logic [3:0] code_at;
        n_valid = 0; n_rel = 0; lat = 0; found = 1'b0; col_at = 4'h0; code_at = 4'h0;
        check({tag, "_idle_col"}, col, 4'b1111);
        @(negedge clock);
        keys = mask;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clock); #1;
            if (valid) begin
                n_valid++;
                if (n_valid == 1) begin
                    lat = k; col_at = col; code_at = code;
                end
            end
        end
        check({tag, "_valids"}, n_valid, exp_n);
        if (exp_n > 0 && n_valid > 0) begin
            check({tag, "_latency_ok"}, lat <= LAT_MAX, 1);
            check({tag, "_code"}, code_at, exp_code);
            check({tag, "_col_at_valid"}, col_at, 4'b0001 << exp_code[1:0]);
            last_code = exp_code;
        end
        @(negedge clock);
        keys = 16'h0000;
        for (int k = 1; k <= DEB + 3 && !found; k++) begin
            @(posedge clock); #1;
            if (valid) n_rel++;
            if (col == 4'b1111) found = 1'b1;
        end
        check({tag, "_release_col"}, found, 1);
        repeat (8) begin
            @(posedge clock); #1;
            if (valid) n_rel++;
        end
        check({tag, "_release_valids"}, n_rel, 0);
        check({tag, "_code_hold"}, code, last_code);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [7];
        int          n_b;
        logic [15:0] m;
        int          w;

        vecs[0] = '{16'h0001,                      80, 1, 4'h0};
        vecs[1] = '{16'h8000,                     200, 1, 4'hF};
        vecs[2] = '{16'h0040,                      80, 1, 4'h6};
        vecs[3] = '{16'h0200,                      80, 1, 4'h9};
        vecs[4] = '{16'h0080 | 16'h2000,          120, 1, 4'hD};
        vecs[5] = '{16'h2000,                      80, 1, 4'hD};
        vecs[6] = '{16'h0000,                      60, 0, 4'h0};

        reset_n = 1'b0;
        keys    = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        check("reset_col", col, 4'b1111);
        check("reset_code", code, 4'h0);
        check("reset_valid", valid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        for (int i = 0; i < 7; i++)
            run_phase(vecs[i].keys, vecs[i].hold, vecs[i].exp_valids, vecs[i].exp_code,
                      $sformatf("vec%0d", i));

        // Bounce on key 5: short pulses never survive the debounce window.
        n_b = 0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clock);
            keys = 16'h0020;
            repeat (8) begin @(posedge clock); #1; if (valid) n_b++; end
            @(negedge clock);
            keys = 16'h0000;
            repeat (8) begin @(posedge clock); #1; if (valid) n_b++; end
        end
        check("bounce_valids", n_b, 0);
        check("bounce_code", code, last_code);
        check("bounce_idle_col", col, 4'b1111);
        run_phase(16'h0020, 80, 1, 4'h5, "bounce_stable");

        // Asynchronous reset while key 10 is in its debounce window.
        @(negedge clock);
        keys = 16'h0400;
        repeat (18) @(posedge clock);
        #1;
        check("rst_pre_col", col, 4'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_col", col, 4'b1111);
        check("rst_async_valid", valid, 0);
        check("rst_async_code", code, 4'h0);
        last_code = 4'h0;
        @(negedge clock);
        reset_n = 1'b1;
        run_phase(16'h0400, 80, 1, 4'hA, "rst_recover");

        for (int it = 0; it < 16; it++) begin
            m = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) m = m | (16'(1) << $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) m = m | (16'(1) << $urandom_range(0, 15));
            w = winner(m);
            run_phase(m, $urandom_range(60, 120), 1, 4'(w), $sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 hex keypad: drives the column lines, samples the returned row lines, debounces, and emits a 4-bit key code with a one-cycle valid strobe.
- Sits directly upstream of the keypad row model, whose rows are row[i] = OR over j of (Key[4i+j] AND col[j]).
- Consumes that model's row output and produces the col vector it evaluates.
- Key index convention: code = 4*row + col, i.e. {row_idx[1:0], col_idx[1:0]}.

Parameters:
- SETTLE_CYCLES, 3, cycles each column is driven before rows are sampled; minimum 3 (covers registered col plus 2-FF row sync).
- DEBOUNCE_CYCLES, 16, consecutive stable samples required for press acceptance and for release; minimum 2.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- row  input  4  keypad row lines, active-high, asynchronous to clock.
- col  output  4  column drive, active-high, registered.
- code  output  4  key code of last accepted key, registered.
- valid  output  1  one-cycle strobe marking a newly accepted key.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_n=0, immediate, any state): col=4'b1111, code=4'h0, valid=0, state=IDLE, all counters 0, sync flops 0.
- Sync: row passes through 2 flops to give row_s. All decisions use row_s only.
- Counter cnt: width $clog2(max(SETTLE_CYCLES, DEBOUNCE_CYCLES)) + 1.
- States: IDLE, SCAN, DEBOUNCE, VALID, RELEASE.
- IDLE:
  - col=1111.
  - If row_s != 0: go to SCAN with col_idx=0, cnt=0.
- SCAN:
  - col = one-hot(col_idx). cnt increments each cycle.
  - At cnt == SETTLE_CYCLES-1, sample row_s:
    - row_s != 0: latch row_idx = lowest set bit of row_s, cnt=0, go to DEBOUNCE.
    - else if col_idx == 3: go to IDLE (no key, or glitch).
    - else: col_idx += 1, cnt=0, stay in SCAN.
- DEBOUNCE:
  - col held at one-hot(col_idx).
  - If row_s[row_idx] == 0: go to IDLE. Bounce is rejected; no valid, code unchanged.
  - Else cnt increments. At cnt == DEBOUNCE_CYCLES-1: go to VALID and load code = {row_idx, col_idx}.
- VALID:
  - valid=1 for exactly this one cycle.
  - col held. Next state RELEASE with cnt=0.
- RELEASE:
  - col held at the found column.
  - cnt increments while row_s[row_idx] == 0; cnt resets to 0 when it is 1.
  - At cnt == DEBOUNCE_CYCLES-1: go to IDLE.
- Outputs: valid is 0 in every state except VALID. code holds its value until the next accepted key.
- Held key: produces exactly one valid. No auto-repeat.
- Multiple keys pressed:
  - Lowest column index wins (scan order 0..3).
  - Within that column, lowest row index wins.
  - Other keys are ignored until full release of the captured key.
- Second key pressed while in RELEASE: ignored. It is detected only after the return to IDLE, and only if still held.
- Press lost during SCAN (all four columns read 0): return to IDLE, no valid.
- Worst-case press-to-valid latency: 2 (sync) + 1 + 4*SETTLE_CYCLES + DEBOUNCE_CYCLES + 1 cycles.

Test Plan:
- Key 0 held stable: col cycles 1111 -> 0001; valid pulses once; code=4'h0; after release, col returns to 1111 within DEBOUNCE_CYCLES+3 cycles.
- Key 15 held: scan passes columns 0..2 without match, matches on col=1000; code=4'hF; exactly one valid pulse in 200 held cycles.
- Key 6 (row1, col2) held: code=4'h6. Then key 9 pressed after full release: second valid with code=4'h9.
- Bounce: key 5 asserted for 8 cycles, deasserted, repeated 3 times (DEBOUNCE_CYCLES=16): no valid, code unchanged, FSM back in IDLE. Then a stable hold: valid with code=4'h5.
- Keys 7 and 13 held simultaneously: code=4'hD (col1 scanned before col3); single valid; no further valid until both are released and 13 is pressed again.
- reset_n dropped mid-DEBOUNCE for key 10: col=1111, valid=0, code=0 asynchronously. After reset_n=1 with key still held: normal acceptance, code=4'hA.
